// File: rtl/risc_toy_mem_arb_if.sv
// Bus bundle for risc_toy_mem_arb: fetch requester, data requester and the
// unified memory port.
//
// Handshake: a requester raises *_REQ with its command fields and holds them
// stable until the cycle in which the matching *_GNT is high. The arbiter
// accepts the command at the rising edge that ends that cycle. *_GNT is a
// one-cycle combinational pulse. M_REQ is a one-cycle command strobe. M_RDATA
// is valid exactly LAT cycles after the M_REQ cycle. *_RDATA is meaningful
// only while the matching *_RVALID is high.
interface risc_toy_mem_arb_if #(
  parameter int AW = 30,
  parameter int DW = 32
);
  logic          I_REQ;
  logic [AW-1:0] I_ADDR;
  logic          I_GNT;
  logic          I_RVALID;
  logic [DW-1:0] I_RDATA;
  logic          D_REQ;
  logic          D_RW;
  logic [AW-1:0] D_ADDR;
  logic [DW-1:0] D_WDATA;
  logic          D_GNT;
  logic          D_RVALID;
  logic [DW-1:0] D_RDATA;
  logic          M_REQ;
  logic          M_RW;
  logic [AW-1:0] M_ADDR;
  logic [DW-1:0] M_WDATA;
  logic [DW-1:0] M_RDATA;

  // Arbiter side
  modport slave (
    input  I_REQ, I_ADDR, D_REQ, D_RW, D_ADDR, D_WDATA, M_RDATA,
    output I_GNT, I_RVALID, I_RDATA, D_GNT, D_RVALID, D_RDATA,
           M_REQ, M_RW, M_ADDR, M_WDATA
  );

  // Requesters plus memory side
  modport master (
    output I_REQ, I_ADDR, D_REQ, D_RW, D_ADDR, D_WDATA, M_RDATA,
    input  I_GNT, I_RVALID, I_RDATA, D_GNT, D_RVALID, D_RDATA,
           M_REQ, M_RW, M_ADDR, M_WDATA
  );
endinterface

// File: rtl/risc_toy_mem_arb.sv
// Single-port memory arbiter for the RISC_TOY core. Shares one memory port
// between instruction fetch and data access, one transaction outstanding.
// Optional macro RISC_TOY_ARB_RR_EN: round-robin priority on simultaneous
// requests instead of fixed data-over-fetch priority.
module risc_toy_mem_arb #(
  parameter int AW  = 30,
  parameter int DW  = 32,
  parameter int LAT = 2
) (
  input  logic                CLK,
  input  logic                RSTN,
  risc_toy_mem_arb_if.slave   bus,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // Elaboration-time guard on the latency range supported by the 4-bit counter
  if (LAT < 1 || LAT > 15) begin : g_lat_err
    $error("risc_toy_mem_arb: LAT=%0d outside legal range 1..15", LAT);
  end

  localparam logic [3:0] LAT4 = 4'(LAT);

  state_t        state_q, state_d;
  logic          owner_q, owner_d;   // 1 = data requester owns the transaction
  logic          rw_q, rw_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          d_wins;
  logic          i_gnt, d_gnt;
  logic          rd_hit;

`ifdef RISC_TOY_ARB_RR_EN
  logic          last_q, last_d;     // 1 = data was granted last

  // Round-robin: on a tie the side that was not granted last wins
  always_comb begin
    d_wins = bus.D_REQ && (!bus.I_REQ || !last_q);
    last_d = last_q;
    if (d_gnt)      last_d = 1'b1;
    else if (i_gnt) last_d = 1'b0;
  end

  // Last-owner register, resets to data so fetch wins the first tie
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) last_q <= 1'b1;
    else       last_q <= last_d;
  end
`else
  // Fixed priority: the data access belongs to the older instruction
  always_comb begin
    d_wins = bus.D_REQ;
  end
`endif

  // Next-state, grant and command-latch logic
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    i_gnt   = 1'b0;
    d_gnt   = 1'b0;
    case (state_q)
      IDLE: begin
        // RSTN gating keeps grants low while reset is held
        if (RSTN && d_wins) begin
          d_gnt   = 1'b1;
          owner_d = 1'b1;
          rw_d    = bus.D_RW;
          addr_d  = bus.D_ADDR;
          wdata_d = bus.D_WDATA;
          state_d = ISSUE;
        end else if (RSTN && bus.I_REQ) begin
          i_gnt   = 1'b1;
          owner_d = 1'b0;
          rw_d    = 1'b0;
          addr_d  = bus.I_ADDR;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (rw_q) begin
          state_d = IDLE;
        end else begin
          cnt_d   = LAT4;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and latched-command registers
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output decode: command fields only change on the edge into ISSUE
  always_comb begin
    rd_hit       = (state_q == WAIT) && (cnt_q == 4'd1);
    bus.I_GNT    = i_gnt;
    bus.D_GNT    = d_gnt;
    bus.I_RVALID = rd_hit && !owner_q;
    bus.D_RVALID = rd_hit && owner_q;
    bus.I_RDATA  = bus.M_RDATA;
    bus.D_RDATA  = bus.M_RDATA;
    bus.M_REQ    = (state_q == ISSUE);
    bus.M_RW     = rw_q;
    bus.M_ADDR   = addr_q;
    bus.M_WDATA  = wdata_q;
    dbg_state    = state_q;
  end

endmodule

// File: tb/tb_risc_toy_mem_arb.sv
// Directed bench for risc_toy_mem_arb (LAT=2). Expectations follow the
// cycle timing of the arbiter; tie-break expectations switch on
// RISC_TOY_ARB_RR_EN.
module tb_risc_toy_mem_arb;

  localparam int AW = 30;
  localparam int DW = 32;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic       CLK;
  logic       RSTN;
  logic [1:0] dbg_state;
  int         checks;
  int         failures;
  logic       first_d;
  logic       exp_d;

  risc_toy_mem_arb_if #(.AW(AW), .DW(DW)) bus();

  risc_toy_mem_arb #(.AW(AW), .DW(DW), .LAT(2)) dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock and watchdog
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Advance to 1 ns after the next rising edge
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    RSTN = 1'b0;
    step();
    RSTN = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    RSTN = 1'b0;
    bus.I_REQ = 1'b0; bus.I_ADDR = '0;
    bus.D_REQ = 1'b0; bus.D_RW = 1'b0; bus.D_ADDR = '0; bus.D_WDATA = '0;
    bus.M_RDATA = '0;

    // Reset state, including a request held during reset
    #2;
    bus.I_REQ = 1'b1;
    #1;
    chk("rst_i_gnt",   bus.I_GNT, 0);
    chk("rst_d_gnt",   bus.D_GNT, 0);
    chk("rst_m_req",   bus.M_REQ, 0);
    chk("rst_m_rw",    bus.M_RW, 0);
    chk("rst_m_addr",  bus.M_ADDR, 0);
    chk("rst_m_wdata", bus.M_WDATA, 0);
    chk("rst_rvalid",  {bus.I_RVALID, bus.D_RVALID}, 0);
    chk("rst_state",   dbg_state, S_IDLE);
    bus.I_REQ = 1'b0;
    step();
    RSTN = 1'b1;
    step();

    // Fetch read, LAT=2
    bus.I_REQ = 1'b1; bus.I_ADDR = 30'h10;
    #1;
    chk("f_t0_i_gnt", bus.I_GNT, 1);
    chk("f_t0_d_gnt", bus.D_GNT, 0);
    step();
    bus.I_REQ = 1'b0;
    #1;
    chk("f_t1_m_req",  bus.M_REQ, 1);
    chk("f_t1_m_rw",   bus.M_RW, 0);
    chk("f_t1_m_addr", bus.M_ADDR, 30'h10);
    chk("f_t1_state",  dbg_state, S_ISSUE);
    step();
    #1;
    chk("f_t2_m_req",  bus.M_REQ, 0);
    chk("f_t2_rvalid", bus.I_RVALID, 0);
    chk("f_t2_state",  dbg_state, S_WAIT);
    step();
    bus.M_RDATA = 32'hDEADBEEF;
    bus.I_REQ = 1'b1; bus.I_ADDR = 30'h14;   // rises in the RVALID cycle
    #1;
    chk("f_t3_i_rvalid", bus.I_RVALID, 1);
    chk("f_t3_i_rdata",  bus.I_RDATA, 32'hDEADBEEF);
    chk("f_t3_d_rvalid", bus.D_RVALID, 0);
    chk("f_t3_i_gnt",    bus.I_GNT, 0);
    step();
    bus.M_RDATA = '0;
    #1;
    chk("f_t4_i_gnt", bus.I_GNT, 1);
    step();
    bus.I_REQ = 1'b0;
    #1;
    chk("f2_m_addr", bus.M_ADDR, 30'h14);
    step();
    step();
    bus.M_RDATA = 32'hCAFEF00D;
    #1;
    chk("f2_i_rvalid", bus.I_RVALID, 1);
    chk("f2_i_rdata",  bus.I_RDATA, 32'hCAFEF00D);
    step();
    bus.M_RDATA = '0;

    // Data write, then a back-to-back write two cycles later
    bus.D_REQ = 1'b1; bus.D_RW = 1'b1; bus.D_ADDR = 30'h20; bus.D_WDATA = 32'h12345678;
    #1;
    chk("w_t0_d_gnt", bus.D_GNT, 1);
    chk("w_t0_i_gnt", bus.I_GNT, 0);
    step();
    bus.D_REQ = 1'b0;
    #1;
    chk("w_t1_m_req",   bus.M_REQ, 1);
    chk("w_t1_m_rw",    bus.M_RW, 1);
    chk("w_t1_m_addr",  bus.M_ADDR, 30'h20);
    chk("w_t1_m_wdata", bus.M_WDATA, 32'h12345678);
    chk("w_t1_d_gnt",   bus.D_GNT, 0);
    step();
    bus.D_REQ = 1'b1; bus.D_ADDR = 30'h24; bus.D_WDATA = 32'hA5A5A5A5;
    #1;
    chk("w_t2_m_req",  bus.M_REQ, 0);
    chk("w_t2_hold_rw",   bus.M_RW, 1);
    chk("w_t2_hold_addr", bus.M_ADDR, 30'h20);
    chk("w_t2_rvalid", {bus.I_RVALID, bus.D_RVALID}, 0);
    chk("w_t2_d_gnt",  bus.D_GNT, 1);
    step();
    bus.D_REQ = 1'b0;
    #1;
    chk("w2_m_addr",  bus.M_ADDR, 30'h24);
    chk("w2_m_wdata", bus.M_WDATA, 32'hA5A5A5A5);
    step();
    #1;
    chk("w2_rvalid", {bus.I_RVALID, bus.D_RVALID}, 0);
    chk("w2_state",  dbg_state, S_IDLE);

    // Simultaneous requests after a fresh reset; each side drops on its grant
    do_reset();
`ifdef RISC_TOY_ARB_RR_EN
    first_d = 1'b0;
`else
    first_d = 1'b1;
`endif
    bus.I_REQ = 1'b1; bus.I_ADDR = 30'h30;
    bus.D_REQ = 1'b1; bus.D_RW = 1'b0; bus.D_ADDR = 30'h40;
    #1;
    chk("s_t0_d_gnt", bus.D_GNT, first_d);
    chk("s_t0_i_gnt", bus.I_GNT, !first_d);
    step();
    if (first_d) bus.D_REQ = 1'b0;
    else         bus.I_REQ = 1'b0;
    #1;
    chk("s_t1_m_addr", bus.M_ADDR, first_d ? 30'h40 : 30'h30);
    chk("s_t1_i_gnt",  bus.I_GNT | bus.D_GNT, 0);
    step();
    step();
    bus.M_RDATA = 32'h11112222;
    #1;
    chk("s_t3_d_rvalid", bus.D_RVALID, first_d);
    chk("s_t3_i_rvalid", bus.I_RVALID, !first_d);
    step();
    bus.M_RDATA = '0;
    #1;
    chk("s_t4_d_gnt", bus.D_GNT, !first_d);
    chk("s_t4_i_gnt", bus.I_GNT, first_d);
    step();
    bus.I_REQ = 1'b0; bus.D_REQ = 1'b0;
    step();
    step();
    bus.M_RDATA = 32'h33334444;
    #1;
    chk("s_t7_d_rvalid", bus.D_RVALID, !first_d);
    chk("s_t7_i_rvalid", bus.I_RVALID, first_d);
    chk("s_t7_d_rdata",  bus.D_RDATA, 32'h33334444);
    step();
    bus.M_RDATA = '0;

    // Both requests held for four transactions
    bus.I_REQ = 1'b1; bus.I_ADDR = 30'h74;
    bus.D_REQ = 1'b1; bus.D_RW = 1'b0; bus.D_ADDR = 30'h70;
    for (int k = 0; k < 4; k++) begin
`ifdef RISC_TOY_ARB_RR_EN
      exp_d = (k % 2 == 1);
`else
      exp_d = 1'b1;
`endif
      #1;
      chk($sformatf("h%0d_d_gnt", k), bus.D_GNT, exp_d);
      chk($sformatf("h%0d_i_gnt", k), bus.I_GNT, !exp_d);
      step();
      #1;
      chk($sformatf("h%0d_m_addr", k), bus.M_ADDR, exp_d ? 30'h70 : 30'h74);
      step();
      step();
      #1;
      chk($sformatf("h%0d_d_rvalid", k), bus.D_RVALID, exp_d);
      chk($sformatf("h%0d_i_rvalid", k), bus.I_RVALID, !exp_d);
      step();
    end
    bus.I_REQ = 1'b0; bus.D_REQ = 1'b0;
    step();

    // Busy blocking: data request during a fetch read's WAIT state
    bus.I_REQ = 1'b1; bus.I_ADDR = 30'h50;
    #1;
    chk("b_t0_i_gnt", bus.I_GNT, 1);
    step();
    bus.I_REQ = 1'b0;
    step();
    bus.D_REQ = 1'b1; bus.D_RW = 1'b0; bus.D_ADDR = 30'h58;
    #1;
    chk("b_t2_d_gnt", bus.D_GNT, 0);
    step();
    bus.M_RDATA = 32'h5555AAAA;
    #1;
    chk("b_t3_d_gnt",    bus.D_GNT, 0);
    chk("b_t3_i_rvalid", bus.I_RVALID, 1);
    step();
    bus.M_RDATA = '0;
    #1;
    chk("b_t4_d_gnt", bus.D_GNT, 1);
    step();
    bus.D_REQ = 1'b0;
    step();
    step();
    bus.M_RDATA = 32'h0BADCAFE;
    #1;
    chk("b_t7_d_rvalid", bus.D_RVALID, 1);
    chk("b_t7_d_rdata",  bus.D_RDATA, 32'h0BADCAFE);
    chk("b_t7_i_rvalid", bus.I_RVALID, 0);
    step();
    bus.M_RDATA = '0;

    // Reset mid-read
    bus.I_REQ = 1'b1; bus.I_ADDR = 30'h60;
    #1;
    chk("r_t0_i_gnt", bus.I_GNT, 1);
    step();
    bus.I_REQ = 1'b0;
    step();
    RSTN = 1'b0;
    #1;
    chk("r_t2_state",  dbg_state, S_IDLE);
    chk("r_t2_m_req",  bus.M_REQ, 0);
    chk("r_t2_m_addr", bus.M_ADDR, 0);
    chk("r_t2_m_rw",   bus.M_RW, 0);
    chk("r_t2_rvalid", {bus.I_RVALID, bus.D_RVALID}, 0);
    step();
    bus.M_RDATA = 32'hFFFF0000;   // late data from the aborted read
    #1;
    chk("r_t3_rvalid", {bus.I_RVALID, bus.D_RVALID}, 0);
    RSTN = 1'b1;
    bus.I_REQ = 1'b1; bus.I_ADDR = 30'h64;
    #1;
    chk("r_t3_i_gnt", bus.I_GNT, 1);
    step();
    bus.I_REQ = 1'b0;
    bus.M_RDATA = '0;
    #1;
    chk("r_t4_m_req",  bus.M_REQ, 1);
    chk("r_t4_m_addr", bus.M_ADDR, 30'h64);
    step();
    step();
    bus.M_RDATA = 32'h64646464;
    #1;
    chk("r_t6_i_rvalid", bus.I_RVALID, 1);
    chk("r_t6_i_rdata",  bus.I_RDATA, 32'h64646464);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
